// File: rtl/sweep_sequencer.sv
// rtl/sweep_sequencer.sv - calibration sequencer: H then V sweep, latches position of peak light.
// Optional build macro SWEEP_AVG_EN compares a two-sample average instead of the raw light sample.
module sweep_sequencer #(
  parameter int LIGHT_W       = 10,
  parameter int POS_W         = 9,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 12
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [LIGHT_W-1:0] LIGHT,
  input  logic               CNT_H,
  input  logic               CNT_D,
  output logic               HS,
  output logic               VS,
  output logic [POS_W-1:0]   BEST_H,
  output logic [POS_W-1:0]   BEST_V,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_H_ARM, S_H_SWEEP, S_SETTLE, S_V_ARM, S_V_SWEEP, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [LIGHT_W-1:0]   best_light_q, best_light_d;
  logic [POS_W-1:0]     best_h_q, best_h_d;
  logic [POS_W-1:0]     best_v_q, best_v_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 hs_q, hs_d, vs_q, vs_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LIGHT_W-1:0]   cmp_light;
  logic                 sample, wd_active;

`ifdef SWEEP_AVG_EN
  logic [LIGHT_W-1:0] light_prev_q, light_prev_d;
  logic [LIGHT_W:0]   light_sum;
  assign light_prev_d = LIGHT;
  assign light_sum    = {1'b0, LIGHT} + {1'b0, light_prev_q};
  assign cmp_light    = light_sum[LIGHT_W:1];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) light_prev_q <= '0;
    else        light_prev_q <= light_prev_d;
  end
`else
  assign cmp_light = LIGHT;
`endif

  assign wd_active = (state_q == S_H_ARM) || (state_q == S_H_SWEEP) ||
                     (state_q == S_V_ARM) || (state_q == S_V_SWEEP);

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    best_light_d = best_light_q;
    best_h_d     = best_h_q;
    best_v_d     = best_v_q;
    err_d        = err_q;
    settle_d     = '0;
    wd_d         = '0;
    sample       = 1'b0;
    // The arm cycle that sees count-enable is the first step (pos 0) of the sweep.
    case (state_q)
      S_IDLE: if (START) begin
        state_d      = S_H_ARM;
        err_d        = 1'b0;
        pos_d        = '0;
        best_light_d = '0;
      end
      S_H_ARM:   if (CNT_H) begin sample = 1'b1; state_d = S_H_SWEEP; end
      S_H_SWEEP: if (CNT_H) sample = 1'b1; else state_d = S_SETTLE;
      S_SETTLE: begin
        pos_d        = '0;
        best_light_d = '0;
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_V_ARM;
        else settle_d = settle_q + 1'b1;
      end
      S_V_ARM:   if (CNT_D) begin sample = 1'b1; state_d = S_V_SWEEP; end
      S_V_SWEEP: if (CNT_D) sample = 1'b1; else state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (sample) begin
      if (pos_q != '1) pos_d = pos_q + 1'b1;
      if (cmp_light > best_light_q) begin
        best_light_d = cmp_light;
        if ((state_q == S_V_ARM) || (state_q == S_V_SWEEP)) best_v_d = pos_q;
        else best_h_d = pos_q;
      end
    end
    if (wd_active && (wd_q == '1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if (wd_active && (state_d == state_q)) wd_d = wd_q + 1'b1;
  end

  // Enables rise one cycle after entering the arm state but drop on the exit edge itself.
  always_comb begin
    hs_d   = ((state_q == S_H_ARM) || (state_q == S_H_SWEEP)) &&
             ((state_d == S_H_ARM) || (state_d == S_H_SWEEP));
    vs_d   = ((state_q == S_V_ARM) || (state_q == S_V_SWEEP)) &&
             ((state_d == S_V_ARM) || (state_d == S_V_SWEEP));
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      pos_q        <= '0;
      best_light_q <= '0;
      best_h_q     <= '0;
      best_v_q     <= '0;
      wd_q         <= '0;
      settle_q     <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      best_light_q <= best_light_d;
      best_h_q     <= best_h_d;
      best_v_q     <= best_v_d;
      wd_q         <= wd_d;
      settle_q     <= settle_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign HS     = hs_q;
  assign VS     = vs_q;
  assign BEST_H = best_h_q;
  assign BEST_V = best_v_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb/tb_sweep_sequencer.sv - directed self-checking bench for sweep_sequencer.
module tb_sweep_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N, START, CNT_H, CNT_D;
  logic [9:0] LIGHT;
  logic       HS, VS, BUSY, DONE, ERR;
  logic [8:0] BEST_H, BEST_V;

  int checks = 0;
  int errors = 0;
  int n;
  int dones;

  sweep_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .LIGHT(LIGHT),
    .CNT_H(CNT_H), .CNT_D(CNT_D), .HS(HS), .VS(VS),
    .BEST_H(BEST_H), .BEST_V(BEST_V), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_en(input bit vert, output int cnt);
    cnt = 0;
    while (((vert ? VS : HS) !== 1'b1) && (cnt < 40)) begin
      tick();
      cnt++;
    end
  endtask

  task automatic start_run;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic sweep(input bit vert, input int len, input int p1, input int v1,
                       input int p2, input int v2, input int base);
    for (int k = 0; k < len; k++) begin
      if (vert) CNT_D = 1'b1; else CNT_H = 1'b1;
      LIGHT = 10'((k == p1) ? v1 : ((k == p2) ? v2 : base));
      tick();
    end
    CNT_H = 1'b0;
    CNT_D = 1'b0;
    LIGHT = '0;
    tick();
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; CNT_H = 1'b0; CNT_D = 1'b0; LIGHT = '0;
    tick(); tick();
    check("rst_hs", HS, 0);
    check("rst_vs", VS, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_best_h", BEST_H, 0);
    check("rst_best_v", BEST_V, 0);
    RST_N = 1'b1;
    tick();

    // Nominal run: H peak at step 3, V peak at step 5.
    start_run();
    check("busy_after_start", BUSY, 1);
    check("hs_not_yet", HS, 0);
    wait_en(0, n);
    check("hs_rise_delay", n, 1);
    sweep(0, 8, 3, 40, -1, 0, 5);
    check("hs_drop", HS, 0);
    check("best_h_peak", BEST_H, 3);
    wait_en(1, n);
    check("settle_gap", n, 17);
    check("hs_low_in_v", HS, 0);
    sweep(1, 6, 5, 50, -1, 0, 5);
    check("done_pulse", DONE, 1);
    check("vs_drop", VS, 0);
    check("busy_in_fin", BUSY, 1);
    check("best_v_peak", BEST_V, 5);
    tick();
    check("done_single", DONE, 0);
    check("busy_clear", BUSY, 0);
    check("best_h_hold", BEST_H, 3);

    // Equal peaks: first one wins.
    start_run();
    wait_en(0, n);
    sweep(0, 8, 2, 30, 6, 30, 10);
    check("tie_first_wins", BEST_H, 2);
    wait_en(1, n);
    sweep(1, 3, -1, 0, -1, 0, 1);
    check("flat_best_v", BEST_V, 0);
    tick();

    // 0,100,100,0: averaged compare moves the pick to the second 100.
    start_run();
    wait_en(0, n);
    sweep(0, 4, 1, 100, 2, 100, 0);
`ifdef SWEEP_AVG_EN
    check("avg_pick", BEST_H, 2);
`else
    check("raw_pick", BEST_H, 1);
`endif
    wait_en(1, n);
    sweep(1, 3, 1, 20, -1, 0, 7);
    check("best_v_run3", BEST_V, 1);
    tick();

    // Watchdog: CNT_H never asserted.
    start_run();
    dones = 0;
    repeat (4095) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    check("wd_not_yet", ERR, 0);
    check("wd_hs_high", HS, 1);
    tick();
    check("wd_err", ERR, 1);
    check("wd_hs_low", HS, 0);
    check("wd_busy_low", BUSY, 0);
    check("wd_no_done", dones + int'(DONE), 0);
    check("wd_best_keep", BEST_V, 1);
    tick();
    check("err_sticky", ERR, 1);
    start_run();
    check("err_cleared", ERR, 0);
    check("busy_restart", BUSY, 1);

    // Async reset in the middle of the vertical sweep.
    wait_en(0, n);
    sweep(0, 3, 1, 20, -1, 0, 5);
    check("pre_rst_best_h", BEST_H, 1);
    wait_en(1, n);
    CNT_D = 1'b1;
    tick(); tick();
    check("vs_in_sweep", VS, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_vs", VS, 0);
    check("arst_busy", BUSY, 0);
    check("arst_best_h", BEST_H, 0);
    check("arst_best_v", BEST_V, 0);
    CNT_D = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
